// File: rtl/test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_pkg
// Description : Shared packet types for the bus write packetizer and its
//               downstream packet consumer, plus the FIFO occupancy states.
// Revision    : 1.0 - initial release
// ============================================================================
package test_pkg;

    // Packet id carries the full bus address.
    localparam int WIDTH  = 32;
    localparam int DATA_W = 16;

    typedef logic [WIDTH-1:0] id_t;

    typedef struct packed {
        id_t               id;
        logic [DATA_W-1:0] data;
    } packet_t;

    // Occupancy class of the packet FIFO; the level counter is authoritative.
    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_write_packetizer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Small synchronous FIFO with level counter, synchronous flush
//               and a registered EMPTY/PARTIAL/FULL occupancy state.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import test_pkg::*;
#(
    parameter type T     = test_pkg::packet_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output T                         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    fifo_state_t   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    // State register: pointers, level, storage and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FIFO_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    // Next-state logic: flush wins over push/pop; state follows the new level.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        state_d  = state_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        if (level_d == '0) begin
            state_d = FIFO_EMPTY;
        end else if (level_d == LW'(DEPTH)) begin
            state_d = FIFO_FULL;
        end else begin
            state_d = FIFO_PARTIAL;
        end
    end

    // Outputs: status flags from the occupancy state, head zeroed when empty.
    always_comb begin
        full  = (state_q == FIFO_FULL);
        empty = (state_q == FIFO_EMPTY);
        level = level_q;
        head  = empty ? T'('0) : mem_q[rd_ptr_q];
    end

endmodule
`default_nettype wire

// File: rtl/bus_write_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : bus_write_packetizer
// Description : Bus follower that turns accepted write beats into packets,
//               buffers them in a FIFO and presents them on a valid/ready
//               stream. Read beats are acknowledged and counted only.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_write_packetizer
    import test_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_valid,
    input  logic                     bus_write_enable,
    input  logic [ADDR_WIDTH-1:0]    bus_addr,
    input  logic [DATA_WIDTH-1:0]    bus_data,
    output logic                     bus_ready,
    input  logic                     flush,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output packet_t                  pkt_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]     wr_count,
    output logic [CNT_WIDTH-1:0]     rd_count
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 pop;
    packet_t              push_pkt;
    packet_t              head;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;

    // Bus handshake decode: ready drops while full, flushing or in reset.
    always_comb begin
        bus_ready     = !fifo_full && !flush && !rst;
        wr_accept     = bus_valid && bus_ready && bus_write_enable;
        rd_accept     = bus_valid && bus_ready && !bus_write_enable;
        pkt_valid     = !fifo_empty;
        pop           = pkt_valid && pkt_ready;
        push_pkt.id   = id_t'(bus_addr);
        push_pkt.data = DATA_W'(bus_data);
        pkt_out       = head;
    end

    // Saturating beat counters; untouched by flush.
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (wr_accept && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + CNT_WIDTH'(1);
        end
        if (rd_accept && (rd_count_q != '1)) begin
            rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

    sync_fifo #(
        .T     (packet_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_accept),
        .push_data (push_pkt),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_write_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_write_packetizer
// Description : Directed self-checking bench for bus_write_packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_write_packetizer;
    import test_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_valid;
    logic        bus_write_enable;
    logic [31:0] bus_addr;
    logic [15:0] bus_data;
    logic        bus_ready;
    logic        flush;
    logic        pkt_valid;
    logic        pkt_ready;
    packet_t     pkt_out;
    logic [2:0]  fifo_level;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int errors = 0;
    int checks = 0;

    bus_write_packetizer #(
        .DEPTH      (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_valid        (bus_valid),
        .bus_write_enable (bus_write_enable),
        .bus_addr         (bus_addr),
        .bus_data         (bus_data),
        .bus_ready        (bus_ready),
        .flush            (flush),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_out          (pkt_out),
        .fifo_level       (fifo_level),
        .wr_count         (wr_count),
        .rd_count         (rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus_valid        = 1'b0;
        bus_write_enable = 1'b0;
        bus_addr         = '0;
        bus_data         = '0;
        flush            = 1'b0;
        pkt_ready        = 1'b0;

        // ---- reset state ----
        #1;
        chk("rst_bus_ready", 64'(bus_ready), 64'd0);
        chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("rst_pkt_out",   64'(pkt_out),   64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rel_bus_ready", 64'(bus_ready),  64'd1);
        chk("rel_pkt_valid", 64'(pkt_valid),  64'd0);
        chk("rel_level",     64'(fifo_level), 64'd0);
        chk("rel_wr_count",  64'(wr_count),   64'd0);
        chk("rel_rd_count",  64'(rd_count),   64'd0);

        // ---- single write with pkt_ready high ----
        bus_valid = 1'b1; bus_write_enable = 1'b1;
        bus_addr = 32'h0000_0010; bus_data = 16'hBEEF; pkt_ready = 1'b1;
        chk("single_no_bypass", 64'(pkt_valid), 64'd0);
        tick();
        bus_valid = 1'b0;
        chk("single_valid", 64'(pkt_valid), 64'd1);
        chk("single_pkt",   64'(pkt_out),   {16'h0, 32'h0000_0010, 16'hBEEF});
        chk("single_wr",    64'(wr_count),  64'd1);
        tick();
        chk("single_drained", 64'(pkt_valid),  64'd0);
        chk("single_level",   64'(fifo_level), 64'd0);

        // ---- fill to full, 5th beat held by master ----
        pkt_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus_valid = 1'b1; bus_write_enable = 1'b1;
            bus_addr = 32'h100 + 32'(i); bus_data = 16'(i);
            tick();
        end
        bus_addr = 32'h105; bus_data = 16'h5;
        chk("full_ready",  64'(bus_ready),    64'd0);
        chk("full_level",  64'(fifo_level),   64'd4);
        chk("full_head",   64'(pkt_out),      {16'h0, 32'h101, 16'h1});
        tick();
        chk("full_hold_level", 64'(fifo_level), 64'd4);
        chk("full_hold_wr",    64'(wr_count),   64'd5);
        // Pop while full: no pop-through, ready rises the next cycle.
        pkt_ready = 1'b1;
        chk("full_pop_ready", 64'(bus_ready), 64'd0);
        tick();
        chk("after_pop_level", 64'(fifo_level),  64'd3);
        chk("after_pop_ready", 64'(bus_ready),   64'd1);
        chk("after_pop_head",  64'(pkt_out.data), 64'h2);
        chk("after_pop_wr",    64'(wr_count),     64'd5);
        tick();
        bus_valid = 1'b0;
        chk("fill_push5_level", 64'(fifo_level),  64'd3);
        chk("fill_head3",       64'(pkt_out.data), 64'h3);
        chk("fill_wr5",         64'(wr_count),     64'd6);
        tick();
        chk("fill_head4", 64'(pkt_out.data), 64'h4);
        tick();
        chk("fill_head5", 64'(pkt_out),    {16'h0, 32'h105, 16'h5});
        tick();
        chk("fill_empty", 64'(pkt_valid),  64'd0);
        chk("fill_level", 64'(fifo_level), 64'd0);

        // ---- simultaneous push/pop at level 2 across pointer wrap ----
        pkt_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            bus_valid = 1'b1; bus_write_enable = 1'b1;
            bus_addr = 32'h200 + 32'(i); bus_data = 16'h20 + 16'(i);
            tick();
        end
        pkt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus_addr = 32'h203 + 32'(k); bus_data = 16'h23 + 16'(k);
            chk("pp_head",  64'(pkt_out.data), 64'h21 + 64'(k));
            chk("pp_level", 64'(fifo_level),   64'd2);
            tick();
        end
        bus_valid = 1'b0;
        chk("pp_head7", 64'(pkt_out), {16'h0, 32'h207, 16'h27});
        tick();
        chk("pp_head8", 64'(pkt_out), {16'h0, 32'h208, 16'h28});
        tick();
        chk("pp_empty", 64'(fifo_level), 64'd0);
        chk("pp_wr",    64'(wr_count),   64'd14);

        // ---- read beats ----
        pkt_ready = 1'b0;
        bus_valid = 1'b1; bus_write_enable = 1'b0;
        tick(); tick(); tick();
        bus_valid = 1'b0;
        chk("rd_count", 64'(rd_count),   64'd3);
        chk("rd_level", 64'(fifo_level), 64'd0);
        chk("rd_wr",    64'(wr_count),   64'd14);

        // ---- flush at level 3 ----
        for (int i = 0; i < 3; i++) begin
            bus_valid = 1'b1; bus_write_enable = 1'b1;
            bus_addr = 32'h300 + 32'(i); bus_data = 16'h30 + 16'(i);
            tick();
        end
        chk("pre_flush_level", 64'(fifo_level), 64'd3);
        flush = 1'b1; pkt_ready = 1'b1;
        #1;
        chk("flush_ready", 64'(bus_ready), 64'd0);
        tick();
        flush = 1'b0; bus_valid = 1'b0; pkt_ready = 1'b0;
        chk("flush_level", 64'(fifo_level), 64'd0);
        chk("flush_valid", 64'(pkt_valid),  64'd0);
        chk("flush_wr",    64'(wr_count),   64'd17);
        chk("flush_rd",    64'(rd_count),   64'd3);

        // ---- async reset mid-stream ----
        for (int i = 0; i < 2; i++) begin
            bus_valid = 1'b1; bus_write_enable = 1'b1;
            bus_addr = 32'h400 + 32'(i); bus_data = 16'h40 + 16'(i);
            tick();
        end
        bus_valid = 1'b0;
        chk("pre_rst_level", 64'(fifo_level), 64'd2);
        chk("pre_rst_valid", 64'(pkt_valid),  64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(pkt_valid),  64'd0);
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_wr",    64'(wr_count),   64'd0);
        chk("arst_rd",    64'(rd_count),   64'd0);
        chk("arst_ready", 64'(bus_ready),  64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
